// File: rtl/nios_dbg_pkg.sv
// Shared widths, command layout and virtual-IR encodings for the Nios debug
// command path.
package nios_dbg_pkg;

  localparam int unsigned NIOS_DBG_SR_WIDTH = 38;
  localparam int unsigned NIOS_DBG_IR_WIDTH = 2;

  typedef struct packed {
    logic [NIOS_DBG_IR_WIDTH-1:0] ir;
    logic [NIOS_DBG_SR_WIDTH-1:0] jdo;
  } nios_dbg_cmd_t;

  localparam logic [NIOS_DBG_IR_WIDTH-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [NIOS_DBG_IR_WIDTH-1:0] IR_TRACECTRL = 2'd1;
  localparam logic [NIOS_DBG_IR_WIDTH-1:0] IR_BREAK     = 2'd2;
  localparam logic [NIOS_DBG_IR_WIDTH-1:0] IR_TRACEMEM  = 2'd3;

endpackage

// File: rtl/nios_dbg_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level, cleared by reset.
module nios_dbg_bit_sync
  import nios_dbg_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/nios_dbg_cmd_sysclk_queue.sv
// System-clock receiver for JTAG debug commands: synchronises UDR/UIR strobes,
// queues {ir, sr} snapshots and hands them out over valid/ready.
module nios_dbg_cmd_sysclk_queue
  import nios_dbg_pkg::*;
#(
  parameter int unsigned SR_WIDTH    = NIOS_DBG_SR_WIDTH,
  parameter int unsigned IR_WIDTH    = NIOS_DBG_IR_WIDTH,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [IR_WIDTH-1:0]           ir_in,
  input  logic [SR_WIDTH-1:0]           sr,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic                          cmd_ready,
  input  logic                          overflow_clr,
  output logic                          cmd_valid,
  output logic [IR_WIDTH-1:0]           cmd_ir,
  output logic [SR_WIDTH-1:0]           cmd_jdo,
  output logic [2**IR_WIDTH-1:0]        take_action,
  output logic                          uir_pulse,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = IR_WIDTH + SR_WIDTH;
  localparam int unsigned NA = 2**IR_WIDTH;

  logic udr_sync, uir_sync;
  logic udr_prev_q, uir_prev_q, udr_pulse_q, uir_pulse_q;

  nios_dbg_bit_sync #(.STAGES(SYNC_STAGES)) u_udr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (vs_udr),
    .q       (udr_sync)
  );

  nios_dbg_bit_sync #(.STAGES(SYNC_STAGES)) u_uir_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (vs_uir),
    .q       (uir_sync)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_prev_q  <= 1'b0;
      uir_prev_q  <= 1'b0;
      udr_pulse_q <= 1'b0;
      uir_pulse_q <= 1'b0;
    end else begin
      udr_prev_q  <= udr_sync;
      uir_prev_q  <= uir_sync;
      udr_pulse_q <= udr_sync & ~udr_prev_q;
      uir_pulse_q <= uir_sync & ~uir_prev_q;
    end
  end

  assign uir_pulse = uir_pulse_q;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          overflow_q;
  logic          empty, full, accept, push, drop;
  logic [EW-1:0] head;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign accept = ~empty & cmd_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push   = udr_pulse_q & (~full | accept);
  assign drop   = udr_pulse_q & full & ~accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= {ir_in, sr};
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (accept) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      overflow_q <= drop | (overflow_q & ~overflow_clr);
    end
  end

  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign cmd_valid  = ~empty;
  assign cmd_ir     = cmd_valid ? head[EW-1:SR_WIDTH] : '0;
  assign cmd_jdo    = cmd_valid ? head[SR_WIDTH-1:0] : '0;
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign overflow   = overflow_q;

  always_comb begin
    take_action = '0;
    for (int unsigned i = 0; i < NA; i++) begin
      take_action[i] = accept && (cmd_ir == IR_WIDTH'(i));
    end
  end

endmodule

// File: tb/tb_nios_dbg_cmd_sysclk_queue.sv
// Directed bench for the debug command queue: latency, backpressure, overflow,
// full push+pop, update-IR and reset mid-operation.
module tb_nios_dbg_cmd_sysclk_queue;
  import nios_dbg_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_udr, vs_uir, cmd_ready, overflow_clr;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_jdo;
  logic [3:0]  take_action;
  logic        uir_pulse;
  logic [2:0]  fifo_level;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  nios_dbg_cmd_sysclk_queue dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ir_in        (ir_in),
    .sr           (sr),
    .vs_udr       (vs_udr),
    .vs_uir       (vs_uir),
    .cmd_ready    (cmd_ready),
    .overflow_clr (overflow_clr),
    .cmd_valid    (cmd_valid),
    .cmd_ir       (cmd_ir),
    .cmd_jdo      (cmd_jdo),
    .take_action  (take_action),
    .uir_pulse    (uir_pulse),
    .fifo_level   (fifo_level),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Rise at a negedge, push lands on the 4th posedge, then a low gap.
  task automatic strobe(input logic [1:0] ir, input logic [37:0] d);
    ir_in = ir; sr = d; vs_udr = 1'b1;
    cyc(4);
    vs_udr = 1'b0;
    cyc(4);
  endtask

  initial begin
    reset_n = 1'b0; ir_in = '0; sr = '0; vs_udr = 1'b0; vs_uir = 1'b0;
    cmd_ready = 1'b0; overflow_clr = 1'b0;
    #1;
    check("rst_valid", 64'(cmd_valid), 64'(0));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    check("rst_jdo", 64'(cmd_jdo), 64'(0));
    check("rst_act", 64'(take_action), 64'(0));
    check("rst_uir", 64'(uir_pulse), 64'(0));
    cyc(2);
    reset_n = 1'b1;
    cyc(2);

    // Single command, consumer always ready
    cmd_ready = 1'b1; ir_in = IR_BREAK; sr = 38'h2A_DEAD_BEEF; vs_udr = 1'b1;
    cyc(3);
    check("single_early", 64'(cmd_valid), 64'(0));
    cyc(1);
    check("single_valid", 64'(cmd_valid), 64'(1));
    check("single_act", 64'(take_action), 64'(4'b0100));
    check("single_ir", 64'(cmd_ir), 64'(2));
    check("single_jdo", 64'(cmd_jdo), 64'(38'h2A_DEAD_BEEF));
    cyc(1);
    check("single_gone", 64'(cmd_valid), 64'(0));
    check("single_level", 64'(fifo_level), 64'(0));
    cyc(5);
    vs_udr = 1'b0;
    cyc(4);
    check("single_once", 64'(cmd_valid), 64'(0));

    // Backpressure fill, then drain on consecutive cycles
    cmd_ready = 1'b0;
    for (int i = 1; i <= 4; i++) strobe(2'(i % 4), 38'(i));
    check("bp_level", 64'(fifo_level), 64'(4));
    check("bp_head", 64'(cmd_jdo), 64'(1));
    check("bp_noact", 64'(take_action), 64'(0));
    cyc(2);
    check("bp_stable", 64'(cmd_jdo), 64'(1));
    cmd_ready = 1'b1;
    #1;
    check("bp_jdo1", 64'(cmd_jdo), 64'(1));
    check("bp_act1", 64'(take_action), 64'(4'b0010));
    cyc(1);
    check("bp_jdo2", 64'(cmd_jdo), 64'(2));
    check("bp_act2", 64'(take_action), 64'(4'b0100));
    cyc(1);
    check("bp_jdo3", 64'(cmd_jdo), 64'(3));
    check("bp_act3", 64'(take_action), 64'(4'b1000));
    cyc(1);
    check("bp_jdo4", 64'(cmd_jdo), 64'(4));
    check("bp_act4", 64'(take_action), 64'(4'b0001));
    cyc(1);
    check("bp_empty", 64'(cmd_valid), 64'(0));
    check("bp_level0", 64'(fifo_level), 64'(0));
    check("bp_ovf", 64'(overflow), 64'(0));

    // Overflow: fifth strobe dropped, clear racing a sixth drop keeps the flag
    cmd_ready = 1'b0;
    for (int i = 11; i <= 15; i++) strobe(2'd0, 38'(i));
    check("ovf_set", 64'(overflow), 64'(1));
    check("ovf_level", 64'(fifo_level), 64'(4));
    ir_in = 2'd0; sr = 38'd16; vs_udr = 1'b1;
    cyc(3);
    overflow_clr = 1'b1;
    cyc(1);
    overflow_clr = 1'b0;
    check("ovf_race", 64'(overflow), 64'(1));
    check("ovf_head", 64'(cmd_jdo), 64'(11));
    vs_udr = 1'b0;
    cyc(4);
    overflow_clr = 1'b1;
    cyc(1);
    overflow_clr = 1'b0;
    check("ovf_clr", 64'(overflow), 64'(0));
    cmd_ready = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      #1;
      check("ovf_drain", 64'(cmd_jdo), 64'(i));
      cyc(1);
    end
    check("ovf_absent", 64'(cmd_valid), 64'(0));

    // Full FIFO with push and pop on the same edge
    cmd_ready = 1'b0;
    for (int i = 21; i <= 24; i++) strobe(2'd0, 38'(i));
    ir_in = IR_TRACEMEM; sr = 38'd25; vs_udr = 1'b1;
    cyc(3);
    cmd_ready = 1'b1;
    #1;
    check("pp_act", 64'(take_action), 64'(4'b0001));
    cyc(1);
    cmd_ready = 1'b0;
    #1;
    check("pp_level", 64'(fifo_level), 64'(4));
    check("pp_ovf", 64'(overflow), 64'(0));
    check("pp_head", 64'(cmd_jdo), 64'(22));
    vs_udr = 1'b0;
    cyc(4);
    cmd_ready = 1'b1;
    for (int i = 22; i <= 25; i++) begin
      #1;
      check("pp_drain", 64'(cmd_jdo), 64'(i));
      cyc(1);
    end
    check("pp_empty", 64'(cmd_valid), 64'(0));

    // update-IR with two entries queued
    cmd_ready = 1'b0;
    strobe(2'd1, 38'd31);
    strobe(2'd1, 38'd32);
    vs_uir = 1'b1;
    cyc(2);
    check("uir_early", 64'(uir_pulse), 64'(0));
    cyc(1);
    check("uir_pulse", 64'(uir_pulse), 64'(1));
    cyc(1);
    check("uir_single", 64'(uir_pulse), 64'(0));
    check("uir_level", 64'(fifo_level), 64'(2));
    vs_uir = 1'b0;
    cyc(4);
    check("uir_head", 64'(cmd_jdo), 64'(31));

    // Reset mid-operation with UDR held high across release
    strobe(2'd1, 38'd33);
    check("rm_level3", 64'(fifo_level), 64'(3));
    ir_in = IR_TRACEMEM; sr = 38'd41; vs_udr = 1'b1;
    cyc(1);
    reset_n = 1'b0;
    #1;
    check("rm_valid", 64'(cmd_valid), 64'(0));
    check("rm_level", 64'(fifo_level), 64'(0));
    check("rm_jdo", 64'(cmd_jdo), 64'(0));
    cyc(2);
    reset_n = 1'b1;
    cyc(3);
    check("rm_early", 64'(cmd_valid), 64'(0));
    cyc(1);
    check("rm_new", 64'(cmd_valid), 64'(1));
    check("rm_newjdo", 64'(cmd_jdo), 64'(41));
    cyc(6);
    check("rm_once", 64'(fifo_level), 64'(1));
    cmd_ready = 1'b1;
    #1;
    check("rm_act", 64'(take_action), 64'(4'b1000));
    cyc(1);
    check("rm_drained", 64'(cmd_valid), 64'(0));
    vs_udr = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nios_dbg_cmd_sysclk_queue.md
Name: nios_dbg_cmd_sysclk_queue

Overview:
- Parametrised system-clock-side receiver for JTAG debug-slave commands.
- Synchronises the update-DR and update-IR strobes from the virtual-JTAG TCK domain.
- On each update-DR, captures the instruction register and shift register into a command FIFO.
- Presents commands to the CPU debug unit over a valid/ready handshake with per-instruction one-hot action pulses. Replaces fire-and-forget action decode, so back-to-back JTAG scans are not lost while the CPU is busy.

Parameters:
- SR_WIDTH, 38: width of the JTAG data shift register and of cmd_jdo.
- IR_WIDTH, 2: virtual IR width; 2**IR_WIDTH action lines.
- FIFO_DEPTH, 4: command FIFO entries; power of two, >=2.
- SYNC_STAGES, 2: synchroniser flops per strobe; >=2.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- ir_in, input, IR_WIDTH: TCK-domain IR; stable while vs_udr is high.
- sr, input, SR_WIDTH: TCK-domain shift register; stable while vs_udr is high.
- vs_udr, input, 1: TCK-domain update-DR level, asynchronous.
- vs_uir, input, 1: TCK-domain update-IR level, asynchronous.
- cmd_ready, input, 1: consumer accepts the head entry.
- overflow_clr, input, 1: clears the sticky overflow flag.
- cmd_valid, output, 1: FIFO non-empty.
- cmd_ir, output, IR_WIDTH: IR of the head entry.
- cmd_jdo, output, SR_WIDTH: SR snapshot of the head entry.
- take_action, output, 2**IR_WIDTH: one-hot of cmd_ir, high only on an accept cycle.
- uir_pulse, output, 1: one-cycle pulse per synchronised update-IR.
- fifo_level, output, $clog2(FIFO_DEPTH)+1: current occupancy.
- overflow, output, 1: sticky flag, set when a command is dropped.

Behaviour:
- Reset: all flops clear asynchronously. cmd_valid, take_action, uir_pulse, overflow, fifo_level = 0. cmd_ir/cmd_jdo = 0. Synchroniser chains = 0. Deassertion is used directly; the reset-release synchroniser sits upstream.
- Synchronisers: vs_udr and vs_uir each pass through SYNC_STAGES flops, then one "previous" flop. Rising edge = sync_last & ~prev, registered into udr_pulse / uir_pulse (one cycle).
- Capture: on the cycle udr_pulse is high, ir_in and sr are sampled directly; quasi-static, TCK holds them through UDR. A push of {ir_in, sr} is issued that cycle. No synchroniser on the data.
- Latency: vs_udr rises before edge 1 -> cmd_valid high after edge SYNC_STAGES+2 when the FIFO is empty (4 cycles at default). uir_pulse has the same latency minus 1.
- Handshake:
  - accept = cmd_valid & cmd_ready. The head is popped on that edge.
  - take_action[cmd_ir] = accept, combinational from registered head and cmd_ready.
  - cmd_ir/cmd_jdo must stay stable while cmd_valid & ~cmd_ready.
  - cmd_ready while empty has no effect.
- FIFO: registered circular buffer; wr/rd pointers of $clog2(FIFO_DEPTH)+1 bits wrapping naturally. Full = MSBs differ, low bits equal.
- Push and pop in the same cycle:
  - Allowed at any level, including full; level is unchanged.
  - When empty, the push occurs and nothing pops (no fall-through).
- Push when full without pop: the new command is dropped, FIFO content is unchanged, and overflow sets on the next edge.
- overflow stays set until overflow_clr. If clear and a new drop occur in the same cycle, overflow remains 1.
- update-IR does not flush or alter the FIFO; it only raises uir_pulse.
- Both strobes arriving together each produce their own pulse on the same cycle.
- Reset mid-handshake: the FIFO empties and any in-flight synchroniser state is discarded. A UDR still high at reset release is seen as a new rising edge only if it was low in sync_last/prev; both are 0 after reset, so it is captured once.

Decomposition:
- Package nios_dbg_pkg:
  - NIOS_DBG_SR_WIDTH = 38, NIOS_DBG_IR_WIDTH = 2.
  - Packed typedef nios_dbg_cmd_t {ir, jdo}.
  - IR encodings: IR_OCIMEM = 0, IR_TRACECTRL = 1, IR_BREAK = 2, IR_TRACEMEM = 3.
- Sub-module nios_dbg_bit_sync (parameter STAGES): async-reset flop chain, instantiated twice.
- FIFO stays inline.

Test Plan:
- Single command:
  - Stimulus: ir_in=2, sr=38'h2A_DEAD_BEEF, vs_udr high for 10 cycles, cmd_ready=1.
  - Response: cmd_valid 1 for exactly one cycle, 4 edges after the rise; take_action=4'b0100 that cycle; cmd_jdo=38'h2A_DEAD_BEEF; fifo_level returns to 0.
- Backpressure fill:
  - Stimulus: cmd_ready=0, 4 UDR strobes with sr=1..4.
  - Response: fifo_level=4, head sr=1 held stable. Then cmd_ready=1 yields 1,2,3,4 on consecutive cycles with matching take_action pulses.
- Overflow:
  - Stimulus: 5 strobes with cmd_ready=0.
  - Response: overflow=1 and entry 5 absent; overflow_clr asserted in the same cycle as a 6th drop keeps overflow=1; the next overflow_clr alone clears it.
- Full push+pop:
  - Stimulus: FIFO full, cmd_ready=1 on the capture cycle of a 5th strobe.
  - Response: level stays 4, no overflow, entry 5 is last out.
- UIR:
  - Stimulus: vs_uir pulse while 2 entries are queued.
  - Response: uir_pulse high for exactly 1 cycle, 3 edges after the rise; fifo_level stays 2.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 with 3 entries queued and vs_udr high.
  - Response: all outputs 0 immediately. After release with vs_udr still high, exactly one new command appears.
